// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch/sequencing stage in front of a single-port 32x16 main memory. The
// memory read is combinational and the write happens on the clock edge.
// The block fetches the instruction word at the PC. When the opcode is
// IMM_OP it also fetches the following literal word. It then presents the
// decoded fields to the execute stage and holds them until that stage takes
// them. While an instruction is held, the memory port is lent to the
// execute stage for loads and stores.
//
// Ports
//   Clock, Reset              rising-edge clock, synchronous active-high reset
//   mem_addr/mem_data         memory address and write data
//   mem_wr_en                 memory write enable
//   mem_q                     memory combinational read data
//   ins_valid/ins_ready       instruction handshake towards the execute stage
//   ins_op/rx/ry/rz           instruction nibbles [15:12]/[11:8]/[7:4]/[3:0]
//   ins_imm                   literal word (0 for single-word instructions)
//   ins_pc                    address of the first instruction word
//   pc_ld/pc_new              PC redirect, taken only with the handshake
//   d_req/d_we/d_addr/d_wdata execute-stage data access request
//   d_ack/d_rdata             access performed this cycle, load data
//   dbg_state                 current FSM state (debug visibility)
//
// Handshake: an instruction transfers on a rising edge where ins_valid and
// ins_ready are both 1. ins_valid never drops, and the ins_* fields never
// change, until that transfer has happened. ins_ready may be driven freely
// and is ignored while ins_valid is 0.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        IMM_OP   = 4'hF
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_q,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [3:0]        ins_op,
  output logic [3:0]        ins_rx,
  output logic [3:0]        ins_ry,
  output logic [3:0]        ins_rz,
  output logic [DATA_W-1:0] ins_imm,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              pc_ld,
  input  logic [ADDR_W-1:0] pc_new,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_FETCH_IMM = 2'd1,
    S_HOLD      = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_imm;
  logic [ADDR_W-1:0]   r_ins_pc;
  logic                r_valid;

  logic                w_is_imm;
  logic                w_hs;
  logic                w_d_ack;

  assign w_is_imm = (mem_q[15:12] == IMM_OP);
  assign w_hs     = r_valid & ins_ready;

  // The data port is granted only while an instruction is held, so a fetch
  // never competes with a load/store. Reset blocks the grant, so a store in
  // flight is dropped.
  assign w_d_ack  = d_req & (r_state == S_HOLD) & ~Reset;

  // Next-state and memory-port steering
  always_comb begin
    w_next_state = r_state;
    mem_addr     = r_pc;
    mem_data     = d_wdata;
    mem_wr_en    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_is_imm) w_next_state = S_FETCH_IMM;
        else          w_next_state = S_HOLD;
      end
      S_FETCH_IMM: begin
        w_next_state = S_HOLD;
      end
      S_HOLD: begin
        if (w_hs) w_next_state = S_FETCH;
        if (w_d_ack) begin
          mem_addr  = d_addr;
          mem_wr_en = d_we;
        end
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  // State register and datapath
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_imm    <= '0;
      r_ins_pc <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_FETCH: begin
          r_ir     <= mem_q;
          r_ins_pc <= r_pc;
          r_pc     <= r_pc + PC_ONE;
          // A two-word instruction becomes valid only after its literal arrives.
          if (!w_is_imm) begin
            r_imm   <= '0;
            r_valid <= 1'b1;
          end
        end
        S_FETCH_IMM: begin
          r_imm   <= mem_q;
          r_pc    <= r_pc + PC_ONE;
          r_valid <= 1'b1;
        end
        S_HOLD: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            if (pc_ld) r_pc <= pc_new;
          end
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ins_valid = r_valid;
  assign ins_op    = r_ir[15:12];
  assign ins_rx    = r_ir[11:8];
  assign ins_ry    = r_ir[7:4];
  assign ins_rz    = r_ir[3:0];
  assign ins_imm   = r_imm;
  assign ins_pc    = r_ins_pc;
  assign d_ack     = w_d_ack;
  assign d_rdata   = mem_q;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ins_ready;
  logic        pc_ld;
  logic [4:0]  pc_new;
  logic        d_req;
  logic        d_we;
  logic [4:0]  d_addr;
  logic [15:0] d_wdata;

  // Instance 0: RESET_PC = 0, fully driven
  logic [4:0]  mem_addr0;
  logic [15:0] mem_data0;
  logic        mem_wr_en0;
  logic [15:0] mem_q0;
  logic        ins_valid0;
  logic [3:0]  ins_op0, ins_rx0, ins_ry0, ins_rz0;
  logic [15:0] ins_imm0;
  logic [4:0]  ins_pc0;
  logic        d_ack0;
  logic [15:0] d_rdata0;
  logic [1:0]  dbg_state0;

  // Instance 1: RESET_PC = 31, no data traffic, no redirects
  logic [4:0]  mem_addr1;
  logic [15:0] mem_data1;
  logic        mem_wr_en1;
  logic [15:0] mem_q1;
  logic        ins_valid1;
  logic [3:0]  ins_op1, ins_rx1, ins_ry1, ins_rz1;
  logic [15:0] ins_imm1;
  logic [4:0]  ins_pc1;
  logic        d_ack1;
  logic [15:0] d_rdata1;
  logic [1:0]  dbg_state1;

  logic [15:0] mem0 [32];
  logic [15:0] mem1 [32];

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock ----------------
  always #5 Clock = ~Clock;

  assign mem_q0 = mem0[mem_addr0];
  assign mem_q1 = mem1[mem_addr1];

  instr_fetch_unit #(.RESET_PC(5'd0)) dut0 (
    .Clock(Clock), .Reset(Reset),
    .mem_addr(mem_addr0), .mem_data(mem_data0), .mem_wr_en(mem_wr_en0), .mem_q(mem_q0),
    .ins_valid(ins_valid0), .ins_ready(ins_ready),
    .ins_op(ins_op0), .ins_rx(ins_rx0), .ins_ry(ins_ry0), .ins_rz(ins_rz0),
    .ins_imm(ins_imm0), .ins_pc(ins_pc0),
    .pc_ld(pc_ld), .pc_new(pc_new),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack0), .d_rdata(d_rdata0), .dbg_state(dbg_state0)
  );

  instr_fetch_unit #(.RESET_PC(5'd31)) dut1 (
    .Clock(Clock), .Reset(Reset),
    .mem_addr(mem_addr1), .mem_data(mem_data1), .mem_wr_en(mem_wr_en1), .mem_q(mem_q1),
    .ins_valid(ins_valid1), .ins_ready(ins_ready),
    .ins_op(ins_op1), .ins_rx(ins_rx1), .ins_ry(ins_ry1), .ins_rz(ins_rz1),
    .ins_imm(ins_imm1), .ins_pc(ins_pc1),
    .pc_ld(1'b0), .pc_new(5'd0),
    .d_req(1'b0), .d_we(1'b0), .d_addr(5'd0), .d_wdata(16'd0),
    .d_ack(d_ack1), .d_rdata(d_rdata1), .dbg_state(dbg_state1)
  );

  // ---------------- driver tasks ----------------
  // One clock: capture the memory write request before the edge and apply it
  // to the bench memory at the edge, then settle 1 time unit past the edge.
  task automatic step();
    logic        wr;
    logic [4:0]  a;
    logic [15:0] d;
    @(negedge Clock);
    wr = mem_wr_en0;
    a  = mem_addr0;
    d  = mem_data0;
    @(posedge Clock);
    if (wr) mem0[a] = d;
    #1;
  endtask

  task automatic do_reset();
    Reset     = 1'b1;
    ins_ready = 1'b0;
    pc_ld     = 1'b0;
    pc_new    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    step();
    Reset = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    int          edges;
    logic [3:0]  op, rx, ry, rz;
    logic [15:0] imm;
  } vec_t;

  vec_t vecs [6];

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end

    vecs[0] = '{16'h3012, 16'h0000, 1, 4'h3, 4'h0, 4'h1, 4'h2, 16'h0000};
    vecs[1] = '{16'hA5C7, 16'h1111, 1, 4'hA, 4'h5, 4'hC, 4'h7, 16'h0000};
    vecs[2] = '{16'hFABC, 16'h8001, 2, 4'hF, 4'hA, 4'hB, 4'hC, 16'h8001};
    vecs[3] = '{16'h0000, 16'h2222, 1, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000};
    vecs[4] = '{16'hEFFF, 16'hFFFF, 1, 4'hE, 4'hF, 4'hF, 4'hF, 16'h0000};
    vecs[5] = '{16'hF000, 16'hFFFF, 2, 4'hF, 4'h0, 4'h0, 4'h0, 16'hFFFF};

    // ---- reset state ----
    do_reset();
    check("rst_valid", 32'(ins_valid0), 32'd0);
    check("rst_op",    32'(ins_op0),    32'd0);
    check("rst_imm",   32'(ins_imm0),   32'd0);
    check("rst_ins_pc",32'(ins_pc0),    32'd0);
    check("rst_d_ack", 32'(d_ack0),     32'd0);
    check("rst_state", 32'(dbg_state0), 32'd0);
    check("rst_addr0", 32'(mem_addr0),  32'd0);
    check("rst_addr1", 32'(mem_addr1),  32'd31);

    // ---- table-driven decode ----
    for (int i = 0; i < 6; i++) begin
      mem0[0] = vecs[i].w0;
      mem0[1] = vecs[i].w1;
      do_reset();
      step();
      if (vecs[i].edges == 2) begin
        check($sformatf("v%0d_early_valid", i), 32'(ins_valid0), 32'd0);
        step();
      end
      check($sformatf("v%0d_valid", i),  32'(ins_valid0), 32'd1);
      check($sformatf("v%0d_op", i),     32'(ins_op0), 32'(vecs[i].op));
      check($sformatf("v%0d_rx", i),     32'(ins_rx0), 32'(vecs[i].rx));
      check($sformatf("v%0d_ry", i),     32'(ins_ry0), 32'(vecs[i].ry));
      check($sformatf("v%0d_rz", i),     32'(ins_rz0), 32'(vecs[i].rz));
      check($sformatf("v%0d_imm", i),    32'(ins_imm0), 32'(vecs[i].imm));
      check($sformatf("v%0d_ins_pc", i), 32'(ins_pc0), 32'd0);
    end

    // ---- test 1: back-to-back immediates, then a single-word instruction ----
    mem0[0] = 16'hF000; mem0[1] = 16'h001A; mem0[2] = 16'hF100; mem0[3] = 16'h000F;
    mem0[4] = 16'h2345;
    do_reset();
    ins_ready = 1'b1;
    step(); step();
    check("t1_e2_valid", 32'(ins_valid0), 32'd1);
    check("t1_e2_op",    32'(ins_op0),    32'hF);
    check("t1_e2_rx",    32'(ins_rx0),    32'h0);
    check("t1_e2_imm",   32'(ins_imm0),   32'h001A);
    check("t1_e2_pc",    32'(ins_pc0),    32'd0);
    step(); step(); step();
    check("t1_e5_valid", 32'(ins_valid0), 32'd1);
    check("t1_e5_op",    32'(ins_op0),    32'hF);
    check("t1_e5_rx",    32'(ins_rx0),    32'h1);
    check("t1_e5_imm",   32'(ins_imm0),   32'h000F);
    check("t1_e5_pc",    32'(ins_pc0),    32'd2);
    step(); step();
    check("t1_e7_valid", 32'(ins_valid0), 32'd1);
    check("t1_e7_op",    32'(ins_op0),    32'h2);
    check("t1_e7_imm",   32'(ins_imm0),   32'h0000);
    check("t1_e7_pc",    32'(ins_pc0),    32'd4);

    // ---- test 2: stall in HOLD ----
    mem0[0] = 16'h3012; mem0[1] = 16'h4000;
    do_reset();
    step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t2_stall%0d_valid", k), 32'(ins_valid0), 32'd1);
      check($sformatf("t2_stall%0d_fields", k),
            {16'(ins_imm0), ins_op0, ins_rx0, ins_ry0, ins_rz0}, 32'h0000_3012);
      check($sformatf("t2_stall%0d_pc", k), 32'(mem_addr0), 32'd1);
      step();
    end
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
    check("t2_after_valid", 32'(ins_valid0), 32'd0);
    check("t2_after_state", 32'(dbg_state0), 32'd0);
    check("t2_after_addr",  32'(mem_addr0),  32'd1);

    // ---- test 3: store then load in HOLD ----
    mem0[0] = 16'hD010; mem0[1] = 16'h0000; mem0[5'h1A] = 16'h0000;
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 5'h1A; d_wdata = 16'h1234;
    #1;
    check("t3_fetch_no_ack",  32'(d_ack0),     32'd0);
    check("t3_fetch_no_wr",   32'(mem_wr_en0), 32'd0);
    step();
    check("t3_st_ack",   32'(d_ack0),     32'd1);
    check("t3_st_wr",    32'(mem_wr_en0), 32'd1);
    check("t3_st_addr",  32'(mem_addr0),  32'h1A);
    step();
    check("t3_mem_1a",   32'(mem0[5'h1A]), 32'h1234);
    d_we = 1'b0;
    #1;
    check("t3_ld_ack",   32'(d_ack0),     32'd1);
    check("t3_ld_wr",    32'(mem_wr_en0), 32'd0);
    check("t3_ld_data",  32'(d_rdata0),   32'h1234);
    // Store to the next fetch address in the same cycle as the handshake
    d_we = 1'b1; d_addr = 5'd1; d_wdata = 16'h5123; ins_ready = 1'b1;
    #1;
    check("t3_both_ack", 32'(d_ack0), 32'd1);
    step();
    d_req = 1'b0; d_we = 1'b0; ins_ready = 1'b0;
    check("t3_both_state", 32'(dbg_state0), 32'd0);
    step();
    check("t3_fwd_valid", 32'(ins_valid0), 32'd1);
    check("t3_fwd_fields", {16'(ins_imm0), ins_op0, ins_rx0, ins_ry0, ins_rz0}, 32'h0000_5123);
    check("t3_fwd_pc",    32'(ins_pc0), 32'd1);

    // ---- test 4: immediate wrapping from 31 to 0 (instance 1) ----
    mem1[31] = 16'hF000; mem1[0] = 16'hABCD; mem1[1] = 16'h7000;
    do_reset();
    step();
    check("t4_e1_valid", 32'(ins_valid1), 32'd0);
    check("t4_e1_addr",  32'(mem_addr1),  32'd0);
    step();
    check("t4_valid",  32'(ins_valid1), 32'd1);
    check("t4_ins_pc", 32'(ins_pc1),    32'd31);
    check("t4_imm",    32'(ins_imm1),   32'hABCD);
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
    check("t4_next_addr", 32'(mem_addr1), 32'd1);

    // ---- test 5: PC redirect ----
    mem0[0] = 16'h1000; mem0[1] = 16'h6000; mem0[5] = 16'h0020;
    do_reset();
    step();
    pc_ld = 1'b1; pc_new = 5'd5;
    step();
    check("t5_noshake_valid", 32'(ins_valid0), 32'd1);
    check("t5_noshake_addr",  32'(mem_addr0),  32'd1);
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0; pc_ld = 1'b0;
    check("t5_redirect_addr", 32'(mem_addr0), 32'd5);
    step();
    check("t5_ins_pc", 32'(ins_pc0), 32'd5);
    check("t5_op",     32'(ins_op0), 32'd0);
    check("t5_ry",     32'(ins_ry0), 32'd2);

    // ---- test 6: reset mid-operation ----
    mem0[0] = 16'hF000; mem0[1] = 16'h0777;
    do_reset();
    step();
    check("t6_in_fimm", 32'(dbg_state0), 32'd1);
    Reset = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 5'd9; d_wdata = 16'hBEEF;
    #1;
    check("t6_fimm_wr",  32'(mem_wr_en0), 32'd0);
    check("t6_fimm_ack", 32'(d_ack0),     32'd0);
    step();
    Reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    check("t6_valid",  32'(ins_valid0), 32'd0);
    check("t6_fields", {16'(ins_imm0), ins_op0, ins_rx0, ins_ry0, ins_rz0}, 32'd0);
    check("t6_ins_pc", 32'(ins_pc0),    32'd0);
    check("t6_addr",   32'(mem_addr0),  32'd0);
    step(); step();
    check("t6_restart_valid", 32'(ins_valid0), 32'd1);
    check("t6_restart_imm",   32'(ins_imm0),   32'h0777);
    // Reset while in HOLD with a store requested must not write
    mem0[0] = 16'h2000;
    do_reset();
    step();
    Reset = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 5'd9;
    #1;
    check("t6_hold_wr",  32'(mem_wr_en0), 32'd0);
    check("t6_hold_ack", 32'(d_ack0),     32'd0);
    step();
    Reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    check("t6_hold_rst_valid", 32'(ins_valid0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch/sequencing stage that drives the single-port 32x16 main memory, which has a combinational read and a write on the Clock edge.
- Fetches instruction words at the PC.
- Assembles two-word immediate instructions (opcode F: instruction word plus 16-bit literal).
- Presents decoded fields to the execute stage through a valid/ready handshake.
- Multiplexes the memory port between instruction fetch and execute-stage load/store accesses.

Parameters:
ADDR_W, 5, memory address / PC width (32 words)
DATA_W, 16, memory word and instruction width
RESET_PC, 0, PC value loaded on reset
IMM_OP, 4'hF, opcode whose instruction is followed by one literal word

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
mem_addr  out  ADDR_W  memory address
mem_data  out  DATA_W  memory write data
mem_wr_en  out  1  memory write enable
mem_q  in  DATA_W  memory combinational read data
ins_valid  out  1  decoded instruction available
ins_ready  in  1  execute stage consumes instruction
ins_op  out  4  instruction [15:12]
ins_rx  out  4  instruction [11:8]
ins_ry  out  4  instruction [7:4]
ins_rz  out  4  instruction [3:0]
ins_imm  out  DATA_W  literal word (0 if not IMM_OP)
ins_pc  out  ADDR_W  address of first instruction word
pc_ld  in  1  redirect PC (sampled with handshake)
pc_new  in  ADDR_W  redirect target
d_req  in  1  execute-stage data access request
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  access performed this cycle
d_rdata  out  DATA_W  load data (= mem_q)

Behaviour:
Reset state:
- State = FETCH, pc = RESET_PC.
- ins_valid = 0, all ins_* fields = 0.
- d_ack = 0.
- mem_wr_en forced to 0 combinationally whenever Reset = 1, in any state.
- Reset mid-operation discards any partial instruction and any pending access.

FETCH:
- mem_addr = pc, mem_wr_en = 0.
- At the edge: ir <= mem_q, ins_pc <= pc, pc <= pc+1.
- If mem_q[15:12] == IMM_OP, go to FETCH_IMM; otherwise ins_imm <= 0, ins_valid <= 1, go to HOLD.

FETCH_IMM:
- mem_addr = pc.
- At the edge: ins_imm <= mem_q, pc <= pc+1, ins_valid <= 1, go to HOLD.

HOLD:
- ins_valid = 1; all ins_* outputs stable until the handshake.
- On ins_valid & ins_ready at the edge: ins_valid <= 0, go to FETCH.
  - If pc_ld = 1 at that edge, pc <= pc_new; otherwise pc is unchanged.
- pc_ld is ignored without the handshake.

Data port:
- Serviced only in HOLD; d_ack = d_req & (state == HOLD) & ~Reset.
- While acked: mem_addr = d_addr, mem_data = d_wdata, mem_wr_en = d_we.
- d_rdata = mem_q, valid in the same cycle as the ack.
- A store completes at that edge.
- d_req in FETCH/FETCH_IMM: no ack; the requester holds d_req.
- d_req and ins_ready in the same cycle are both honoured.
- A store to the next fetch address is visible to that fetch.

Latency:
- Single-word instruction: ins_valid 1 edge after entering FETCH.
- Immediate instruction: ins_valid 2 edges after entering FETCH.
- Minimum throughput: 2 cycles per single-word instruction (FETCH + HOLD).

Arithmetic:
- pc increments modulo 2^ADDR_W: 31 -> 0.
- An immediate whose opcode word sits at 31 takes its literal from address 0.

mem_data = d_wdata whenever no store is active (don't-care, but deterministic).

Test Plan:
1. Mem[0..3] = F000, 001A, F100, 000F; ins_ready = 1.
   -> Edge 2: valid, op=F, rx=0, imm=001A, ins_pc=0.
   -> Edge 5: op=F, rx=1, imm=000F, ins_pc=2.
2. Mem[0] = 3012; ins_ready = 0 for 3 cycles, then 1.
   -> Valid after edge 1: op=3, rx=0, ry=1, rz=2, imm=0.
   -> Outputs and pc=1 stable while stalled; FETCH of address 1 follows the handshake.
3. Mem[0] = D010; in HOLD, d_req=1, d_we=1, d_addr=1A, d_wdata=1234.
   -> d_ack = 1, mem_wr_en = 1, Mem[1A] = 1234 after the edge.
   -> Following load (d_we=0) of 1A returns d_rdata = 1234 with d_ack in the same cycle.
4. RESET_PC = 31, Mem[31] = F000, Mem[0] = ABCD.
   -> ins_pc = 31, imm = ABCD, next fetch from address 1.
5. Handshake with pc_ld=1, pc_new=5, Mem[5] = 0020.
   -> Next instruction: ins_pc=5, op=0, ry=2.
   -> pc_ld=1 with ins_ready=0 has no effect.
6. Reset asserted in FETCH_IMM with d_req=1, d_we=1.
   -> mem_wr_en = 0 that cycle; after the edge ins_valid = 0, ins_* = 0.
   -> Fetch restarts at RESET_PC.
